krnl_idct_mul_arbiter: RTL and testbench

//  Shares one pipelined signed 16x16->16 DSP multiplier among NUM_REQ requesters in the IDCT kernel.
//  - Round-robin grant, at most one operand pair issued per cycle.
//  - Each operation carries a requester-ID tag alongside the multiplier pipeline.
//  - Results return on one shared tagged stream with backpressure, which stalls the multiplier's ce.

---
 rtl/krnl_idct_mul_arbiter_pkg.sv | 13 +
 rtl/krnl_idct_mul_arbiter_mul.sv | 33 +++
 rtl/krnl_idct_mul_arbiter.sv | 86 ++++++++
 tb/tb_krnl_idct_mul_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/krnl_idct_mul_arbiter_pkg.sv
// Shared constants for the IDCT multiplier arbiter and its DSP core.
// The tag pipe depth is taken from MUL_LAT, so both always match the core.
package krnl_idct_mul_arbiter_pkg;

    // Register stages inside the multiplier core: operand, product, output.
    localparam int MUL_LAT = 3;

    // Operand / result width of the shared multiplier.
    localparam int OP_W = 16;

    typedef logic signed [OP_W-1:0] op_t;

endpackage

// File: rtl/krnl_idct_mul_arbiter_mul.sv
// 16s x 16s -> 16 pipelined multiplier (DSP48 style).
// Three ce-gated stages; the product is truncated to the low 16 bits (wraps).
module krnl_idct_mul_arbiter_mul
    import krnl_idct_mul_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic ce,
    input  op_t  din0,
    input  op_t  din1,
    output op_t  dout
);

    op_t a_r, b_r, p_r, dout_r;

    // Operand -> product -> output registers, all frozen when ce is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r    <= '0;
            b_r    <= '0;
            p_r    <= '0;
            dout_r <= '0;
        end else if (ce) begin
            a_r    <= din0;
            b_r    <= din1;
            p_r    <= op_t'(a_r * b_r);
            dout_r <= p_r;
        end
    end

    assign dout = dout_r;

endmodule

// File: rtl/krnl_idct_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among NUM_REQ requesters.
// Each issued op carries its requester ID down a tag pipe alongside the core;
// a stalled result stream freezes both the core and the tags.
module krnl_idct_mul_arbiter
    import krnl_idct_mul_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [OP_W*NUM_REQ-1:0] req_a,
    input  logic [OP_W*NUM_REQ-1:0] req_b,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [ID_W-1:0]         res_id,
    output logic [OP_W-1:0]         res_data,
    output logic                    busy
);

    logic                          ce;
    logic                          found;
    logic                          xfer;
    logic [ID_W-1:0]               gnt_idx;
    logic [ID_W-1:0]               scan_idx;
    logic [ID_W-1:0]               ptr;
    logic [MUL_LAT-1:0]            vld_pipe;
    logic [MUL_LAT-1:0][ID_W-1:0]  id_pipe;
    op_t                           din0, din1, dout;

    // Pipeline advances unless a presented result is being held off.
    assign ce = ~(res_valid & ~res_ready);

    // Round-robin pick starting at ptr, operand mux, and one-hot accept.
    always_comb begin
        found    = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req_valid[scan_idx]) begin
                found   = 1'b1;
                gnt_idx = scan_idx;
            end
        end
        // No accept while in reset, so nothing slips in before the tags clear.
        xfer      = found & ce & ~reset;
        req_ready = xfer ? (NUM_REQ'(1) << gnt_idx) : '0;
        // Idle cycles feed zeros; the cleared tag keeps the result invisible.
        din0      = xfer ? op_t'(req_a[gnt_idx*OP_W +: OP_W]) : '0;
        din1      = xfer ? op_t'(req_b[gnt_idx*OP_W +: OP_W]) : '0;
    end

    // RR pointer moves past the winner; tag pipe shifts in lockstep with the core.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= '0;
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            if (xfer)
                ptr <= (int'(gnt_idx) == NUM_REQ-1) ? '0 : gnt_idx + 1'b1;
            if (ce) begin
                vld_pipe <= {vld_pipe[MUL_LAT-2:0], xfer};
                id_pipe  <= {id_pipe[MUL_LAT-2:0], gnt_idx};
            end
        end
    end

    krnl_idct_mul_arbiter_mul u_mul (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .din0  (din0),
        .din1  (din1),
        .dout  (dout)
    );

    assign res_valid = vld_pipe[MUL_LAT-1];
    assign res_id    = id_pipe[MUL_LAT-1];
    assign res_data  = dout;
    assign busy      = |vld_pipe;

endmodule

// File: tb/tb_krnl_idct_mul_arbiter.sv
// Directed bench for krnl_idct_mul_arbiter: a vector table for single ops,
// then hand-sequenced RR order, backpressure, mid-flight reset and pointer wrap.
module tb_krnl_idct_mul_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a, req_b;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_id;
    logic [15:0] res_data;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    krnl_idct_mul_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_data  (res_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Advance one edge and land 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int id, input logic [15:0] a, input logic [15:0] b);
        req_a[id*16 +: 16] = a;
        req_b[id*16 +: 16] = b;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        res_ready = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic chk_res(input string nm, input logic v, input int id, input logic [15:0] d);
        chk({nm, " res_valid"}, 32'(res_valid), 32'(v));
        if (v) begin
            chk({nm, " res_id"}, 32'(res_id), 32'(id));
            chk({nm, " res_data"}, 32'(res_data), 32'(d));
        end
    endtask

    initial begin
        vecs[0] = '{"3x-5",         2, 16'h0003, 16'hFFFB, 16'hFFF1};
        vecs[1] = '{"-32768x-1",    0, 16'h8000, 16'hFFFF, 16'h8000};
        vecs[2] = '{"300x300",      1, 16'd300,  16'd300,  16'h5F90};
        vecs[3] = '{"max x max",    3, 16'h7FFF, 16'h7FFF, 16'h0001};
        vecs[4] = '{"-1x-1",        0, 16'hFFFF, 16'hFFFF, 16'h0001};
        vecs[5] = '{"256x256 wrap", 1, 16'h0100, 16'h0100, 16'h0000};
        vecs[6] = '{"-256x2",       3, 16'hFF00, 16'h0002, 16'hFE00};

        // Reset state: no accept even with every requester asserting.
        reset     = 1'b1;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        step();
        step();
        chk("rdy during reset", 32'(req_ready), 32'h0);
        reset     = 1'b0;
        req_valid = '0;
        step();
        chk("reset res_valid", 32'(res_valid), 32'h0);
        chk("reset res_id", 32'(res_id), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);

        // Single-op vectors: one-cycle accept, result MUL_LAT edges later.
        for (int v = 0; v < 7; v++) begin
            req_valid = 4'(1 << vecs[v].id);
            set_op(vecs[v].id, vecs[v].a, vecs[v].b);
            #1;
            chk({vecs[v].name, " req_ready"}, 32'(req_ready), 32'(1 << vecs[v].id));
            step();
            req_valid = '0;
            #1;
            chk({vecs[v].name, " req_ready drop"}, 32'(req_ready), 32'h0);
            chk_res({vecs[v].name, " early"}, 1'b0, 0, 16'h0);
            step();
            chk_res({vecs[v].name, " early2"}, 1'b0, 0, 16'h0);
            step();
            chk_res(vecs[v].name, 1'b1, vecs[v].id, vecs[v].exp);
            chk({vecs[v].name, " busy"}, 32'(busy), 32'h1);
            step();
            chk_res({vecs[v].name, " after"}, 1'b0, 0, 16'h0);
            chk({vecs[v].name, " busy after"}, 32'(busy), 32'h0);
        end

        // All four requesting: grants and results rotate 0,1,2,3.
        do_reset();
        for (int s = 0; s < 12; s++) begin
            if (s == 0) begin
                req_valid = 4'hF;
                for (int i = 0; i < 4; i++) set_op(i, 16'(i + 1), 16'd10);
            end
            if (s == 8) req_valid = '0;
            #1;
            chk($sformatf("rr s%0d req_ready", s), 32'(req_ready),
                (s < 8) ? 32'(1 << (s % 4)) : 32'h0);
            if (s >= 3 && s < 11)
                chk_res($sformatf("rr s%0d", s), 1'b1, (s - 3) % 4, 16'(((s - 3) % 4 + 1) * 10));
            else
                chk_res($sformatf("rr s%0d", s), 1'b0, 0, 16'h0);
            step();
        end

        // Backpressure: 5 stalled cycles hold the result and block grants.
        do_reset();
        for (int s = 0; s < 13; s++) begin
            logic [3:0] er;
            if (s == 0) begin
                req_valid = 4'b0111;
                for (int i = 0; i < 3; i++) set_op(i, 16'(i + 1), 16'd7);
                set_op(3, 16'd5, 16'd5);
            end
            if (s == 3) begin
                req_valid = 4'b1000;
                res_ready = 1'b0;
            end
            if (s == 8) res_ready = 1'b1;
            if (s == 9) req_valid = '0;
            #1;
            case (s)
                0:       er = 4'b0001;
                1:       er = 4'b0010;
                2:       er = 4'b0100;
                8:       er = 4'b1000;
                default: er = 4'b0000;
            endcase
            chk($sformatf("bp s%0d req_ready", s), 32'(req_ready), 32'(er));
            if (s >= 3 && s <= 8)      chk_res($sformatf("bp s%0d", s), 1'b1, 0, 16'd7);
            else if (s == 9)           chk_res("bp s9", 1'b1, 1, 16'd14);
            else if (s == 10)          chk_res("bp s10", 1'b1, 2, 16'd21);
            else if (s == 11)          chk_res("bp s11", 1'b1, 3, 16'd25);
            else                       chk_res($sformatf("bp s%0d", s), 1'b0, 0, 16'h0);
            if (s == 12) chk("bp busy end", 32'(busy), 32'h0);
            step();
        end

        // Reset with three ops in flight, then a clean op from requester 0.
        do_reset();
        for (int s = 0; s < 12; s++) begin
            if (s == 0) begin
                req_valid = 4'b0110;
                set_op(0, 16'd9, 16'hFFFC);
                set_op(1, 16'd11, 16'd11);
                set_op(2, 16'd12, 16'd12);
                set_op(3, 16'd2, 16'd2);
            end
            if (s == 3) begin
                req_valid = '0;
                reset     = 1'b1;
            end
            if (s == 4) reset = 1'b0;
            if (s == 7) req_valid = 4'b1001;
            if (s == 8) req_valid = '0;
            #1;
            if (s == 0) chk("mrst s0 req_ready", 32'(req_ready), 32'h2);
            if (s == 1) chk("mrst s1 req_ready", 32'(req_ready), 32'h4);
            if (s == 2) chk("mrst s2 req_ready", 32'(req_ready), 32'h2);
            if (s == 3) begin
                chk_res("mrst s3", 1'b1, 1, 16'd121);
                chk("mrst s3 busy", 32'(busy), 32'h1);
            end
            if (s >= 4 && s <= 9) begin
                chk_res($sformatf("mrst s%0d", s), 1'b0, 0, 16'h0);
                chk($sformatf("mrst s%0d busy", s), 32'(busy), (s >= 8) ? 32'h1 : 32'h0);
            end
            if (s == 7) chk("mrst first grant", 32'(req_ready), 32'h1);
            if (s == 10) chk_res("mrst s10", 1'b1, 0, 16'hFFDC);
            if (s == 11) begin
                chk_res("mrst s11", 1'b0, 0, 16'h0);
                chk("mrst s11 busy", 32'(busy), 32'h0);
            end
            step();
        end

        // Pointer at 2 with requesters 1 and 3: 3 wins, then 1.
        do_reset();
        for (int s = 0; s < 7; s++) begin
            if (s == 0) begin
                req_valid = 4'b0010;
                set_op(1, 16'd4, 16'd5);
                set_op(3, 16'hFFFD, 16'd6);
            end
            if (s == 1) req_valid = 4'b1010;
            if (s == 3) req_valid = '0;
            #1;
            if (s == 0) chk("ptr s0 req_ready", 32'(req_ready), 32'h2);
            if (s == 1) chk("ptr s1 req_ready", 32'(req_ready), 32'h8);
            if (s == 2) chk("ptr s2 req_ready", 32'(req_ready), 32'h2);
            if (s == 3) chk_res("ptr s3", 1'b1, 1, 16'd20);
            if (s == 4) chk_res("ptr s4", 1'b1, 3, 16'hFFEE);
            if (s == 5) chk_res("ptr s5", 1'b1, 1, 16'd20);
            if (s == 6) begin
                chk_res("ptr s6", 1'b0, 0, 16'h0);
                chk("ptr s6 busy", 32'(busy), 32'h0);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
